// File: rtl/small_poly_sampler_if.sv
// Handshake and data bundle between the poly sampler, its RandomNG and the coefficient consumer.
// master = requester/consumer side, slave = sampler side.
interface small_poly_sampler_if;
    logic        start;
    logic [31:0] seed_in;
    logic [31:0] seed_out;
    logic [12:0] rand_in;
    logic [12:0] coef;
    logic        coef_valid;
    logic        coef_ready;
    logic [9:0]  coef_idx;
    logic        busy;
    logic        done;
    logic [9:0]  weight;
    logic        weight_ok;

    modport master (
        output start, seed_in, rand_in, coef_ready,
        input  seed_out, coef, coef_valid, coef_idx, busy, done, weight, weight_ok
    );

    modport slave (
        input  start, seed_in, rand_in, coef_ready,
        output seed_out, coef, coef_valid, coef_idx, busy, done, weight, weight_ok
    );
endinterface

// File: rtl/small_poly_sampler.sv
// Streams N legalised {0,1,-1} coefficients from an external RNG keyed by an xorshift32 state; optional SMALL_POLY_WEIGHT_CHECK_EN counts nonzero weight.
// Latency: 2 cycles from accepted start to first coef_valid, then 1 coefficient per cycle.
// Backpressure: coef, coef_idx and the generator state hold while coef_ready is low.
module small_poly_sampler #(
    parameter int N = 757,
    parameter int W = 286
) (
    input  logic                 clk,
    input  logic                 rst,
    small_poly_sampler_if.slave  bus
);

    typedef enum logic [1:0] {IDLE, FILL, OUT, DONE} state_t;

    localparam logic [9:0] LAST_IDX = 10'(N - 1);

    state_t      state;
    state_t      state_nxt;
    logic [31:0] s_q;
    logic [12:0] coef_q;
    logic [9:0]  idx_q;
    logic [12:0] rand_legal;
    logic        xfer;
    logic        coef_valid_c;
    logic        done_c;
    logic        busy_c;

    function automatic logic [31:0] xorshift32(input logic [31:0] s);
        logic [31:0] t;
        t = s ^ (s << 13);
        t = t ^ (t >> 17);
        t = t ^ (t << 5);
        return t;
    endfunction

    // Only 0, +1 and -1 are legal coefficients; anything else from the RNG collapses to 0.
    always_comb begin
        rand_legal = 13'd0;
        if (bus.rand_in == 13'd0 || bus.rand_in == 13'd1 || bus.rand_in == 13'h1FFF)
            rand_legal = bus.rand_in;
    end

    assign xfer = (state == OUT) && bus.coef_ready;

    always_comb begin
        state_nxt    = state;
        coef_valid_c = 1'b0;
        done_c       = 1'b0;
        busy_c       = (state != IDLE);
        case (state)
            IDLE: if (bus.start) state_nxt = FILL;
            FILL: state_nxt = OUT;
            OUT: begin
                coef_valid_c = 1'b1;
                if (xfer && idx_q == LAST_IDX) state_nxt = DONE;
            end
            DONE: begin
                done_c    = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            s_q    <= 32'd0;
            coef_q <= 13'd0;
            idx_q  <= 10'd0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (bus.start) begin
                        // An all-zero xorshift state would lock up, so substitute 1.
                        s_q   <= (bus.seed_in == 32'd0) ? 32'd1 : bus.seed_in;
                        idx_q <= 10'd0;
                    end
                end
                FILL: begin
                    coef_q <= rand_legal;
                    s_q    <= xorshift32(s_q);
                end
                OUT: begin
                    if (xfer && idx_q != LAST_IDX) begin
                        idx_q  <= idx_q + 10'd1;
                        coef_q <= rand_legal;
                        s_q    <= xorshift32(s_q);
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.seed_out   = s_q;
    assign bus.coef       = coef_q;
    assign bus.coef_idx   = idx_q;
    assign bus.coef_valid = coef_valid_c;
    assign bus.done       = done_c;
    assign bus.busy       = busy_c;

`ifdef SMALL_POLY_WEIGHT_CHECK_EN
    logic [9:0] weight_q;

    always_ff @(posedge clk) begin
        if (rst)
            weight_q <= 10'd0;
        else if (state == IDLE && bus.start)
            weight_q <= 10'd0;
        else if (xfer && coef_q != 13'd0)
            weight_q <= weight_q + 10'd1;
    end

    assign bus.weight    = weight_q;
    assign bus.weight_ok = (state == DONE) && (weight_q == 10'(W));
`else
    assign bus.weight    = 10'd0;
    assign bus.weight_ok = 1'b0;
`endif

endmodule

// File: tb/tb_small_poly_sampler.sv
// Self-checking bench for small_poly_sampler: a stub RandomNG plus a sequence-level reference model.
module tb_small_poly_sampler;
    localparam int N = 757;
    localparam int W = 286;

    logic clk = 1'b0;
    logic rst;

    small_poly_sampler_if bus ();

    small_poly_sampler #(.N(N), .W(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int          n_chk     = 0;
    int          n_fail    = 0;
    int          gmode     = 0;
    logic [12:0] force_val = 13'd0;
    int          nz_target = 0;

    function automatic logic [31:0] xs_ref(input logic [31:0] s);
        logic [31:0] a;
        a = s ^ (s << 13);
        a = a ^ (a >> 17);
        return a ^ (a << 5);
    endfunction

    function automatic logic [12:0] rng_hash(input logic [31:0] s);
        case (s[1:0])
            2'd0:    return 13'd0;
            2'd1:    return 13'd1;
            2'd2:    return 13'h1FFF;
            default: return s[20:8];
        endcase
    endfunction

    function automatic logic [12:0] legal_ref(input logic [12:0] v);
        return (v inside {13'd0, 13'd1, 13'h1FFF}) ? v : 13'd0;
    endfunction

    function automatic logic [12:0] exp_coef(input int k, input logic [31:0] sk);
        case (gmode)
            0:       return legal_ref(rng_hash(sk));
            1:       return legal_ref(force_val);
            default: return (k < nz_target) ? 13'h1FFF : 13'd0;
        endcase
    endfunction

    // Stub RandomNG; mode 2 keys on the index about to be captured to force an exact weight.
    always_comb begin
        bus.rand_in = 13'd0;
        case (gmode)
            0:       bus.rand_in = rng_hash(bus.seed_out);
            1:       bus.rand_in = force_val;
            default: bus.rand_in = ((bus.coef_valid ? int'(bus.coef_idx) + 1 : 0) < nz_target)
                                   ? 13'h1FFF : 13'd5;
        endcase
    end

    task automatic do_reset();
        bus.start      = 1'b0;
        bus.coef_ready = 1'b0;
        rst            = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic run_poly(input logic [31:0] seed, input int gm, input int rmode,
                            input int abort_at, input bit hold_start);
        logic [31:0] sq [N+1];
        logic [12:0] exp_c;
        int          nhs, nz, cyc;
        bit          fin, aborted, r;
        gmode = gm;
        sq[0] = (seed == 32'd0) ? 32'd1 : seed;
        for (int k = 0; k < N; k++) sq[k+1] = xs_ref(sq[k]);
        nhs = 0; nz = 0; cyc = 0; fin = 1'b0; aborted = 1'b0;

        @(negedge clk);
        bus.seed_in    = seed;
        bus.start      = 1'b1;
        bus.coef_ready = 1'b0;
        @(negedge clk);
        if (!hold_start) bus.start = 1'b0;
        bus.seed_in = ~seed;
        n_chk++;
        if (bus.seed_out !== sq[0] || bus.coef_valid !== 1'b0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL fill_state: seed_out=%h valid=%b busy=%b, want seed_out=%h valid=0 busy=1",
                     bus.seed_out, bus.coef_valid, bus.busy, sq[0]);
        end
        @(negedge clk);
        n_chk++;
        if (bus.coef_valid !== 1'b1 || bus.seed_out !== sq[1] || bus.weight_ok !== 1'b0) begin
            n_fail++;
            $display("FAIL first_valid: valid=%b seed_out=%h weight_ok=%b, want valid=1 seed_out=%h weight_ok=0",
                     bus.coef_valid, bus.seed_out, bus.weight_ok, sq[1]);
        end

        while (!fin && cyc < 4*N + 20) begin
            if (nhs == N) begin
                n_chk++;
                if (bus.done !== 1'b1 || bus.coef_valid !== 1'b0 || bus.busy !== 1'b1) begin
                    n_fail++;
                    $display("FAIL done_cycle: done=%b valid=%b busy=%b, want done=1 valid=0 busy=1",
                             bus.done, bus.coef_valid, bus.busy);
                end
                n_chk++;
`ifdef SMALL_POLY_WEIGHT_CHECK_EN
                if (bus.weight !== 10'(nz) || bus.weight_ok !== (nz == W)) begin
                    n_fail++;
                    $display("FAIL weight_done: weight=%0d ok=%b, want weight=%0d ok=%b",
                             bus.weight, bus.weight_ok, nz, (nz == W));
                end
`else
                if (bus.weight !== 10'd0 || bus.weight_ok !== 1'b0) begin
                    n_fail++;
                    $display("FAIL weight_off: weight=%0d ok=%b, want 0 0", bus.weight, bus.weight_ok);
                end
`endif
                fin = 1'b1;
            end else if (nhs == abort_at) begin
                bus.coef_ready = 1'b1;
                rst = 1'b1;
                @(negedge clk);
                n_chk++;
                if ({bus.busy, bus.done, bus.coef_valid, bus.weight_ok} !== 4'b0 ||
                    bus.seed_out !== 32'd0 || bus.coef !== 13'd0 ||
                    bus.coef_idx !== 10'd0 || bus.weight !== 10'd0) begin
                    n_fail++;
                    $display("FAIL abort_reset: busy=%b done=%b valid=%b seed=%h coef=%h idx=%0d weight=%0d, want all 0",
                             bus.busy, bus.done, bus.coef_valid, bus.seed_out, bus.coef, bus.coef_idx, bus.weight);
                end
                rst = 1'b0;
                bus.coef_ready = 1'b0;
                @(negedge clk);
                n_chk++;
                if (bus.coef_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL abort_release: valid=%b done=%b busy=%b, want 0 0 0",
                             bus.coef_valid, bus.done, bus.busy);
                end
                r = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    @(negedge clk);
                    if (bus.done === 1'b1) r = 1'b1;
                end
                n_chk++;
                if (r) begin
                    n_fail++;
                    $display("FAIL abort_no_done: done pulsed=1, want 0");
                end
                fin = 1'b1;
                aborted = 1'b1;
            end else begin
                exp_c = exp_coef(nhs, sq[nhs]);
                n_chk++;
                if (bus.coef_valid !== 1'b1 || bus.coef_idx !== 10'(nhs) ||
                    bus.coef !== exp_c || bus.seed_out !== sq[nhs+1]) begin
                    n_fail++;
                    $display("FAIL stream[%0d]: valid=%b idx=%0d coef=%h seed=%h, want valid=1 idx=%0d coef=%h seed=%h",
                             nhs, bus.coef_valid, bus.coef_idx, bus.coef, bus.seed_out, nhs, exp_c, sq[nhs+1]);
                end
                case (rmode)
                    0:       r = 1'b1;
                    1:       r = ((cyc % 2) == 0);
                    default: r = 1'($urandom_range(1, 0));
                endcase
                bus.coef_ready = r;
                if (r) begin
                    if (exp_c != 13'd0) nz++;
                    nhs++;
                end
                @(negedge clk);
                cyc++;
            end
        end

        n_chk++;
        if (!fin) begin
            n_fail++;
            $display("FAIL run_timeout: handshakes=%0d after %0d cycles, want %0d", nhs, cyc, N);
        end
        bus.coef_ready = 1'b0;
        if (fin && !aborted) begin
            @(negedge clk);
            n_chk++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.coef_valid !== 1'b0) begin
                n_fail++;
                $display("FAIL post_done: done=%b busy=%b valid=%b, want 0 0 0",
                         bus.done, bus.busy, bus.coef_valid);
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        bus.start = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.busy, bus.done, bus.coef_valid, bus.weight_ok} !== 4'b0 || bus.seed_out !== 32'd0 ||
            bus.coef !== 13'd0 || bus.coef_idx !== 10'd0 || bus.weight !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_state: busy=%b done=%b valid=%b seed=%h coef=%h idx=%0d, want all 0",
                     bus.busy, bus.done, bus.coef_valid, bus.seed_out, bus.coef, bus.coef_idx);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        n_chk++;
        if (bus.coef_valid !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_release: valid=%b done=%b busy=%b, want 0 0 0",
                     bus.coef_valid, bus.done, bus.busy);
        end
    endtask

    task automatic test_seed_one();
        run_poly(32'h1, 0, 0, -1, 1'b0);
    endtask

    task automatic test_zero_seed();
        run_poly(32'h0, 0, 2, -1, 1'b0);
    endtask

    task automatic test_ready_toggle();
        run_poly(32'hDEADBEEF, 0, 1, -1, 1'b0);
    endtask

    task automatic test_legalise();
        force_val = 13'd5;
        run_poly(32'hCAFE0001, 1, 2, -1, 1'b0);
        force_val = 13'h1FFF;
        run_poly(32'h0BADF00D, 1, 0, -1, 1'b0);
    endtask

    task automatic test_weight();
        nz_target = W;
        run_poly(32'h55AA55AA, 2, 0, -1, 1'b0);
        nz_target = W - 1;
        run_poly(32'h13572468, 2, 2, -1, 1'b0);
    endtask

    task automatic test_reset_mid();
        run_poly(32'h00C0FFEE, 0, 0, 300, 1'b0);
        run_poly(32'h1, 0, 2, -1, 1'b0);
    endtask

    task automatic test_back_to_back();
        logic [31:0] seed;
        seed = 32'h12345678;
        run_poly(seed, 0, 0, -1, 1'b1);
        @(negedge clk);
        n_chk++;
        if (bus.busy !== 1'b1 || bus.coef_valid !== 1'b0 || bus.coef_idx !== 10'd0 || bus.seed_out !== ~seed) begin
            n_fail++;
            $display("FAIL back_to_back: busy=%b valid=%b idx=%0d seed=%h, want busy=1 valid=0 idx=0 seed=%h",
                     bus.busy, bus.coef_valid, bus.coef_idx, bus.seed_out, ~seed);
        end
        do_reset();
    endtask

    task automatic test_random();
        for (int i = 0; i < 2; i++) run_poly($urandom, 0, 2, -1, 1'b0);
    endtask

    initial begin
        rst            = 1'b1;
        bus.start      = 1'b0;
        bus.seed_in    = 32'd0;
        bus.coef_ready = 1'b0;
        test_reset();
        test_seed_one();
        test_zero_seed();
        test_ready_toggle();
        test_legalise();
        test_weight();
        test_reset_mid();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/small_poly_sampler.md
SMALL_POLY_SAMPLER -- requirements
Module: small_poly_sampler

Interface
REQ-001 SHALL have parameter N, default 757, the number of coefficients per polynomial.
REQ-002 SHALL have parameter W, default 286, the target nonzero weight (used only under REQ-027).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port start, input, 1 bit: request a new polynomial; sampled only in IDLE.
REQ-006 SHALL have port seed_in, input, 32 bits: initial generator state, captured on an accepted start.
REQ-007 SHALL have port seed_out, output, 32 bits: current state register S, driven to the RandomNG seed input.
REQ-008 SHALL have port rand_in, input, 13 bits: two's-complement sample returned by RandomNG for seed_out.
REQ-009 SHALL have port coef, output, 13 bits: the registered coefficient, two's complement.
REQ-010 SHALL have port coef_valid, output, 1 bit, and port coef_ready, input, 1 bit: the stream handshake.
REQ-011 SHALL have port coef_idx, output, 10 bits: the index of the coefficient currently presented.
REQ-012 SHALL have port busy, output, 1 bit, and port done, output, 1 bit.
REQ-013 SHALL have port weight, output, 10 bits, and port weight_ok, output, 1 bit.

Function
REQ-014 SHALL implement an FSM with states IDLE, FILL, OUT and DONE; busy = (state != IDLE).
REQ-015 SHALL, in IDLE with start=1, load S with seed_in (or 32'h1 if seed_in==0), clear coef_idx, and go to FILL.
REQ-016 SHALL, in FILL, set coef to the legalised rand_in, advance S by one xorshift32 step, and go to OUT.
REQ-017 SHALL define the xorshift32 step as three updates in order: S^=S<<13, then S^=S>>17, then S^=S<<5.
REQ-018 SHALL legalise rand_in as follows: the values 13'd0, 13'd1 and 13'h1FFF pass unchanged; any other value becomes 13'd0.
REQ-019 SHALL assert coef_valid only in OUT; while ready is low, coef, coef_idx and S SHALL hold.
REQ-020 SHALL, on a handshake in OUT with coef_idx < N-1, increment coef_idx, capture the next legalised rand_in, advance S, and stay in OUT.
  - Throughput: 1 coefficient per cycle.
REQ-021 SHALL, on a handshake in OUT with coef_idx == N-1, go to DONE; exactly N handshakes occur per polynomial.
REQ-022 SHALL pulse done high for exactly one cycle in DONE, then return to IDLE.
REQ-023 SHALL ignore start outside IDLE; start held high SHALL begin a new run on the cycle after DONE.
REQ-024 SHALL give a latency of 2 cycles from start to the first coef_valid.

Reset
REQ-025 SHALL, on rst=1, enter IDLE and zero S, coef, coef_idx, weight and all flags.
  - rst SHALL take priority over every other input, including during OUT.
  - A run in flight SHALL be abandoned without a done pulse.
REQ-026 SHALL hold coef_valid=0 and done=0 in the first cycle after rst is released.

Configuration
REQ-027 SHALL, with macro SMALL_POLY_WEIGHT_CHECK_EN defined:
  - count accepted nonzero coefficients in weight, cleared on an accepted start;
  - drive weight_ok = (weight == W) during the done cycle, 0 otherwise.
REQ-028 SHALL, without that macro, keep the weight and weight_ok ports and drive both to constant 0.

Verification
REQ-029 Seed 32'h1, start pulse, ready=1 -> seed_out=32'h00042021 one cycle after FILL; coef_valid high 2 cycles after start; done exactly 757 handshakes later.
REQ-030 Seed 32'h0 -> seed_out=32'h1 in FILL (lock-up avoided).
REQ-031 ready toggled 1/0 every cycle -> 757 coefficients, no index skipped or repeated, coef stable while ready=0.
REQ-032 rst asserted at coef_idx=300 -> next cycle IDLE, all outputs 0, no done pulse; a new start then restarts from index 0.
REQ-033 Forced rand_in=13'd5 -> coef=0; rand_in=13'h1FFF -> coef=13'h1FFF.
REQ-034 With SMALL_POLY_WEIGHT_CHECK_EN and a model forcing exactly 286 nonzero coefficients -> weight=286 and weight_ok=1 in the done cycle; with 285 nonzero -> weight_ok=0.
